// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and RAM-side signals of the byte-serial memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between fetch and load/store (MEM wins), optional fetch abort under IF_ABORT_EN
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t            state_q, state_d;
  logic              own_mem_q, own_mem_d;
  logic [ADDR_W-1:0] base_q, base_d, ram_a_q, ram_a_d;
  logic [2:0]        cnt_q, cnt_d, n_q, n_d, nxt;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic [7:0]        ram_dout_q, ram_dout_d, wbyte;
  logic              ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              flush;

  if (RAM_LAT != 1) begin : g_bad_lat
    $error("mem_arbiter supports RAM_LAT == 1 only");
  end

`ifdef IF_ABORT_EN
  assign flush = bus.if_flush;
`else
  logic unused_flush;
  assign flush = 1'b0;
  assign unused_flush = bus.if_flush;
`endif

  // Grant, byte sequencing, read-data assembly and abort handling
  always_comb begin
    state_d = state_q;
    own_mem_d = own_mem_q;
    base_d = base_q;
    cnt_d = cnt_q;
    n_d = n_q;
    wdata_d = wdata_q;
    buf_d = buf_q;
    if_data_d = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_dout_d = ram_dout_q;
    ram_a_d = '0;
    ram_wr_d = 1'b0;
    if_done_d = 1'b0;
    mem_done_d = 1'b0;
    nxt = cnt_q + 3'd1;
    wbyte = 8'(wdata_q >> {nxt, 3'b000});
    case (state_q)
      IDLE: begin
        if (bus.mem_req || (bus.if_req && !flush)) begin
          own_mem_d = bus.mem_req;
          base_d = bus.mem_req ? bus.mem_addr : bus.if_addr;
          n_d = !bus.mem_req ? 3'd4 : bus.mem_len == 2'd0 ? 3'd1 : bus.mem_len == 2'd1 ? 3'd2 : 3'd4;
          wdata_d = bus.mem_wdata;
          cnt_d = '0;
          buf_d = '0;
          state_d = (bus.mem_req && bus.mem_we) ? WR : RD;
          ram_a_d = base_d;
          ram_wr_d = bus.mem_req && bus.mem_we;
          ram_dout_d = ram_wr_d ? bus.mem_wdata[7:0] : ram_dout_q;
        end
      end
      RD: begin
        if (cnt_q != 3'd0) buf_d = buf_q | (32'(bus.ram_din) << {cnt_q - 3'd1, 3'b000});
        if (cnt_q == n_q) begin
          state_d = DONE;
          if_done_d = !own_mem_q;
          mem_done_d = own_mem_q;
          if_data_d = own_mem_q ? if_data_q : buf_d;
          mem_rdata_d = own_mem_q ? buf_d : mem_rdata_q;
        end else begin
          cnt_d = nxt;
          ram_a_d = (nxt == n_q) ? '0 : base_q + ADDR_W'(nxt);
        end
      end
      WR: begin
        cnt_d = nxt;
        if (nxt == n_q) begin
          state_d = DONE;
          mem_done_d = 1'b1;
        end else begin
          ram_a_d = base_q + ADDR_W'(nxt);
          ram_wr_d = 1'b1;
          ram_dout_d = wbyte;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush && !own_mem_q && (state_q == RD || state_q == DONE)) begin
      state_d = IDLE;
      if_done_d = 1'b0;
      if_data_d = if_data_q;
      ram_a_d = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_mem_q <= 1'b0;
      base_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      if_data_q <= '0;
      mem_rdata_q <= '0;
      ram_dout_q <= '0;
      ram_a_q <= '0;
      ram_wr_q <= 1'b0;
      if_done_q <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_mem_q <= own_mem_d;
      base_q <= base_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      wdata_q <= wdata_d;
      buf_q <= buf_d;
      if_data_q <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_dout_q <= ram_dout_d;
      ram_a_q <= ram_a_d;
      ram_wr_q <= ram_wr_d;
      if_done_q <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  assign bus.if_done = if_done_q;
  assign bus.if_data = if_data_q;
  assign bus.mem_done = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_a = ram_a_q;
  assign bus.ram_wr = ram_wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a 1-cycle-latency RAM model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.ram_din <= rom(bus.ram_a);

  function automatic logic [7:0] rom(logic [31:0] a);
    case (a)
      32'h1000: rom = 8'h13;
      32'h1001: rom = 8'h05;
      32'h1002, 32'h1003: rom = 8'h00;
      32'h20: rom = 8'hAB;
      default: rom = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] a, int n);
    load_val = '0;
    for (int k = 0; k < n; k++) load_val[8*k +: 8] = rom(a + 32'(k));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output bit di, output bit dm, output int at);
    di = 1'b0;
    dm = 1'b0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus.if_done || bus.mem_done) begin
        di = bus.if_done;
        dm = bus.mem_done;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_chk++;
    if ({bus.if_done, bus.mem_done, bus.ram_wr} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, want 000", {bus.if_done, bus.mem_done, bus.ram_wr});
    end
    n_chk++;
    if (bus.ram_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ram_a: got %h, want 00000000", bus.ram_a);
    end
    n_chk++;
    if (bus.ram_dout !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_ram_dout: got %h, want 00", bus.ram_dout);
    end
    n_chk++;
    if ({bus.if_data, bus.mem_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got if_data=%h mem_rdata=%h, want 0", bus.if_data, bus.mem_rdata);
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    bit di, dm;
    int at, t;
    step();
    t = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    exp_q.push_back('{1'b0, 1'b1, 32'h00000513, t + 6});
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++;
      if ({bus.ram_wr, bus.ram_a} !== {1'b0, 32'h1000 + 32'(k)}) begin
        n_fail++;
        $display("FAIL fetch_addr%0d: got wr=%b a=%h, want wr=0 a=%h", k, bus.ram_wr, bus.ram_a, 32'h1000 + 32'(k));
      end
    end
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.if_data !== e.data) begin
      n_fail++;
      $display("FAIL fetch_done: got if=%b mem=%b cyc=%0d data=%h, want cyc=%0d data=%h", di, dm, at, bus.if_data, e.at, e.data);
    end
    step();
    bus.if_req = 1'b0;
  endtask

  task automatic test_contention();
    exp_t e;
    bit di, dm;
    int at, t;
    step();
    t = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_len = 2'd0;
    bus.mem_addr = 32'h20;
    exp_q.push_back('{1'b1, 1'b1, 32'h000000AB, t + 3});
    exp_q.push_back('{1'b0, 1'b1, 32'h00000513, t + 10});
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.mem_rdata !== e.data) begin
      n_fail++;
      $display("FAIL contention_mem: got if=%b mem=%b cyc=%0d data=%h, want mem at cyc=%0d data=%h", di, dm, at, bus.mem_rdata, e.at, e.data);
    end
    step();
    bus.mem_req = 1'b0;
    step();
    n_chk++;
    if (bus.ram_a !== 32'h1000) begin
      n_fail++;
      $display("FAIL contention_if_grant: got ram_a=%h, want 00001000", bus.ram_a);
    end
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.if_data !== e.data) begin
      n_fail++;
      $display("FAIL contention_if: got if=%b mem=%b cyc=%0d data=%h, want if at cyc=%0d data=%h", di, dm, at, bus.if_data, e.at, e.data);
    end
    step();
    bus.if_req = 1'b0;
  endtask

  task automatic test_half_store();
    exp_t e;
    bit di, dm;
    int at, t;
    step();
    t = cyc;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b1;
    bus.mem_len = 2'd1;
    bus.mem_addr = 32'h40;
    bus.mem_wdata = 32'h1234BEEF;
    exp_q.push_back('{1'b1, 1'b0, 32'h0, t + 3});
    step();
    n_chk++;
    if ({bus.ram_wr, bus.ram_a, bus.ram_dout} !== {1'b1, 32'h40, 8'hEF}) begin
      n_fail++;
      $display("FAIL store_byte0: got wr=%b a=%h d=%h, want 1 00000040 ef", bus.ram_wr, bus.ram_a, bus.ram_dout);
    end
    step();
    n_chk++;
    if ({bus.ram_wr, bus.ram_a, bus.ram_dout} !== {1'b1, 32'h41, 8'hBE}) begin
      n_fail++;
      $display("FAIL store_byte1: got wr=%b a=%h d=%h, want 1 00000041 be", bus.ram_wr, bus.ram_a, bus.ram_dout);
    end
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at) begin
      n_fail++;
      $display("FAIL store_done: got if=%b mem=%b cyc=%0d, want mem at cyc=%0d", di, dm, at, e.at);
    end
    n_chk++;
    if ({bus.ram_wr, bus.ram_a} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL store_no_third: got wr=%b a=%h, want wr=0 a=0", bus.ram_wr, bus.ram_a);
    end
    step();
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    bit di, dm;
    int at, t;
    logic [31:0] want;
    step();
    t = cyc;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_len = 2'd2;
    bus.mem_addr = 32'hFFFFFFFE;
    exp_q.push_back('{1'b1, 1'b1, 32'h5B5AA5A4, t + 6});
    for (int k = 0; k < 4; k++) begin
      step();
      want = 32'hFFFFFFFE + 32'(k);
      n_chk++;
      if (bus.ram_a !== want) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got %h, want %h", k, bus.ram_a, want);
      end
    end
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.mem_rdata !== e.data) begin
      n_fail++;
      $display("FAIL wrap_done: got if=%b mem=%b cyc=%0d data=%h, want cyc=%0d data=%h", di, dm, at, bus.mem_rdata, e.at, e.data);
    end
    step();
    bus.mem_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit di, dm, seen;
    int at, t;
    step();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.if_req = 1'b0;
    n_chk++;
    if ({bus.if_done, bus.mem_done, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.if_data, bus.mem_rdata} !== 107'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got a=%h d=%h if_data=%h strobes=%b, want all 0", bus.ram_a, bus.ram_dout, bus.if_data, {bus.if_done, bus.mem_done, bus.ram_wr});
    end
    seen = 1'b0;
    repeat (8) begin
      step();
      seen |= bus.if_done | bus.mem_done;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done pulse, want none");
    end
    t = cyc;
    bus.if_req = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 32'h00000513, t + 6});
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.if_data !== e.data) begin
      n_fail++;
      $display("FAIL reset_mid_refetch: got if=%b mem=%b cyc=%0d data=%h, want cyc=%0d data=%h", di, dm, at, bus.if_data, e.at, e.data);
    end
    step();
    bus.if_req = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    bit di, dm;
    int at, t;
    step();
    t = cyc;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    step();
    step();
    bus.if_flush = 1'b1;
    bus.mem_req = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_len = 2'd0;
    bus.mem_addr = 32'h20;
`ifdef IF_ABORT_EN
    exp_q.push_back('{1'b1, 1'b1, 32'h000000AB, t + 6});
    step();
    bus.if_flush = 1'b0;
    bus.if_req = 1'b0;
`else
    exp_q.push_back('{1'b0, 1'b1, 32'h00000513, t + 6});
    exp_q.push_back('{1'b1, 1'b1, 32'h000000AB, t + 10});
    step();
    bus.if_flush = 1'b0;
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.if_data !== e.data) begin
      n_fail++;
      $display("FAIL abort_ignored_if: got if=%b mem=%b cyc=%0d data=%h, want if at cyc=%0d data=%h", di, dm, at, bus.if_data, e.at, e.data);
    end
    step();
    bus.if_req = 1'b0;
`endif
    wait_done(12, di, dm, at);
    e = exp_q.pop_front();
    n_chk++;
    if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || bus.mem_rdata !== e.data) begin
      n_fail++;
      $display("FAIL abort_mem: got if=%b mem=%b cyc=%0d data=%h, want mem at cyc=%0d data=%h", di, dm, at, bus.mem_rdata, e.at, e.data);
    end
    step();
    bus.mem_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit di, dm;
    int at, t, n;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      step();
      t = cyc;
      a = $urandom();
      if (i % 2 == 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = a;
        exp_q.push_back('{1'b0, 1'b1, load_val(a, 4), t + 6});
      end else begin
        bus.mem_len = 2'($urandom_range(0, 3));
        bus.mem_we = (i % 4 == 3);
        bus.mem_addr = a;
        bus.mem_wdata = $urandom();
        bus.mem_req = 1'b1;
        n = bus.mem_len == 2'd0 ? 1 : bus.mem_len == 2'd1 ? 2 : 4;
        exp_q.push_back('{1'b1, !bus.mem_we, load_val(a, n), t + n + (bus.mem_we ? 1 : 2)});
      end
      wait_done(12, di, dm, at);
      e = exp_q.pop_front();
      n_chk++;
      if ({di, dm} !== {!e.is_mem, e.is_mem} || at !== e.at || (e.chk_data && (e.is_mem ? bus.mem_rdata : bus.if_data) !== e.data)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got if=%b mem=%b cyc=%0d if_data=%h mem_rdata=%h, want mem=%b cyc=%0d data=%h", i, di, dm, at, bus.if_data, bus.mem_rdata, e.is_mem, e.at, e.data);
      end
      step();
      bus.if_req = 1'b0;
      bus.mem_req = 1'b0;
    end
  endtask

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_len = 2'd0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_half_store();
    test_wrap();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
